// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB first, even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits; default build sends one.
module uart_tx_frame #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       parity_bit,
    output logic [7:0] par_data,
    output logic       par_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_CLKS = 2 * CLKS_PER_BIT;
`else
    localparam int STOP_CLKS = CLKS_PER_BIT;
`endif
    localparam int CNT_W = $clog2(STOP_CLKS);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       next_idx;
    logic             bit_end;

    // STOP may span two bit times, so its terminal count differs from the others.
    always_comb begin
        bit_end  = 1'b0;
        next_idx = bit_idx + 3'd1;
        if (state == STOP) begin
            bit_end = (baud_cnt == CNT_W'(STOP_CLKS - 1));
        end else begin
            bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (tx_start) next_state = START;
            START:   if (bit_end) next_state = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) next_state = PARITY;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        par_en  = (state == START) || (state == DATA);
        tx_busy = (state != IDLE);
    end

    // Line driver and bit timing; parity_bit is sampled only at the last data edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            par_data <= 8'h00;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                end else begin
                    baud_cnt <= baud_cnt + CNT_W'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (tx_start) begin
                        par_data <= tx_data;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= par_data[0];
                        bit_idx <= 3'd0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            tx <= parity_bit;
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= par_data[next_idx];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                    end
                end
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame with a two-stage behavioural parity generator.
// Frames are compared bit-by-bit against a list built from the framing rules.
module tb_uart_tx_frame;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam int FRAME = (10 + STOP_BITS) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       parity_bit;
    logic [7:0] par_data;
    logic       par_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       par_stage;

    int checks   = 0;
    int failures = 0;

    uart_tx_frame #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .parity_bit(parity_bit),
        .par_data  (par_data),
        .par_en    (par_en),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream parity generator: two cycles of latency while enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            par_stage  <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            par_stage  <= par_en ? ^par_data : par_stage;
            parity_bit <= par_stage;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic expBit(input logic [7:0] d, input int k);
        logic [11:0] frame_bits;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        frame_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame_bits[i+1] = d[i];
        frame_bits[9]  = (ones % 2 == 1);
        frame_bits[10] = 1'b1;
        frame_bits[11] = 1'b1;
        return frame_bits[k];
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; optionally pulses tx_start with pulse_data at cycle pulse_cycle.
    task automatic applyStimulus(input logic [7:0] data, input int pulse_cycle, input logic [7:0] pulse_data);
        int done_cnt;
        int stop_low;
        done_cnt = 0;
        stop_low = 0;
        tx_data  = data;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        checkOutput("start_tx", tx, 0);
        checkOutput("start_busy", tx_busy, 1);
        checkOutput("done_clear", tx_done, 0);
        for (int c = 1; c <= FRAME; c++) begin
            if (c == pulse_cycle) begin
                tx_start = 1'b1;
                tx_data  = pulse_data;
            end
            @(posedge clk);
            #1;
            tx_start = 1'b0;
            if (tx_done) done_cnt++;
            if (c > 10 * CPB && tx !== 1'b1) stop_low++;
            if (c % CPB == CPB / 2)
                checkOutput($sformatf("bit%0d_%02h", c / CPB, data), tx, expBit(data, c / CPB));
            if (c == CPB / 2) checkOutput("par_en_start", par_en, 1);
            if (c == 9 * CPB + CPB / 2) checkOutput("par_en_parity", par_en, 0);
            if (c == 5 * CPB) checkOutput("par_data", par_data, data);
            if (c == FRAME - 1) checkOutput("busy_last", tx_busy, 1);
        end
        checkOutput("done_now", tx_done, 1);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("busy_end", tx_busy, 0);
        checkOutput("stop_high", stop_low, 0);
    endtask

    initial begin
        int low_cnt;
        int busy_cnt;
        int done_cnt;
        logic [7:0] d;

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #12;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", tx_busy, 0);
        checkOutput("rst_done", tx_done, 0);
        checkOutput("rst_par_en", par_en, 0);
        checkOutput("rst_par_data", par_data, 0);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(2);

        applyStimulus(8'hA5, 0, 8'h00);
        idleCycles(3);
        checkOutput("idle_tx", tx, 1);
        applyStimulus(8'h07, 0, 8'h00);
        idleCycles(2);
        applyStimulus(8'h00, 0, 8'h00);
        idleCycles(2);
        applyStimulus(8'hFF, 0, 8'h00);
        idleCycles(2);

        // A start request during DATA must be dropped, not queued.
        applyStimulus(8'h81, 35, 8'h3C);
        low_cnt  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) low_cnt++;
            if (tx_busy !== 1'b0) busy_cnt++;
        end
        checkOutput("ignored_tx_low", low_cnt, 0);
        checkOutput("ignored_busy", busy_cnt, 0);

        // Back-to-back: second request lands in the tx_done cycle.
        applyStimulus(8'h96, 0, 8'h00);
        applyStimulus(8'h55, 0, 8'h00);
        idleCycles(2);

        // Reset in the middle of a frame.
        tx_data  = 8'hF0;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        idleCycles(45);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", tx, 1);
        checkOutput("midrst_busy", tx_busy, 0);
        checkOutput("midrst_done", tx_done, 0);
        idleCycles(3);
        @(negedge clk);
        rst = 1'b0;
        low_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) low_cnt++;
            if (tx_done !== 1'b0) done_cnt++;
        end
        checkOutput("after_rst_tx_low", low_cnt, 0);
        checkOutput("after_rst_done", done_cnt, 0);
        applyStimulus(8'h12, 0, 8'h00);
        idleCycles(2);

        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            applyStimulus(d, 0, 8'h00);
            idleCycles($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
